// File: rtl/radar_sweep_sequencer.sv
// Sweep sequencer for the radar datapath: steps the servo across N_STEPS angles,
// fires one ultrasonic measurement per angle and tracks the nearest obstacle per sweep.
module radar_sweep_sequencer #(
  parameter int unsigned N_STEPS       = 5,
  parameter int unsigned DUTY_BASE     = 2,
  parameter logic [7:0]  PERIOD_SM     = 8'd20,
  parameter logic [7:0]  PERIOD_US     = 8'd60,
  parameter int unsigned SETTLE_CYCLES = 500000,
  parameter int unsigned US_TIMEOUT    = 300000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic       us_done,
  input  logic [7:0] us_dist,
  output logic       enable_sm,
  output logic       enable_us,
  output logic [7:0] period,
  output logic [3:0] dutty,
  output logic       busy,
  output logic       res_valid,
  output logic [3:0] res_angle,
  output logic [7:0] res_dist,
  output logic       res_tmo,
  output logic       sweep_done,
  output logic [7:0] min_dist,
  output logic [3:0] min_angle
);

  localparam int unsigned CNT_MAX    = (SETTLE_CYCLES > US_TIMEOUT) ? SETTLE_CYCLES : US_TIMEOUT;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);
  localparam logic [3:0]  LAST_STEP  = 4'(N_STEPS - 1);
  localparam logic [3:0]  DBASE      = 4'(DUTY_BASE);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END    = CW'(US_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_GAP, S_MEAS, S_STORE, S_GAP2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    step;
  logic [3:0]    step_nxt;
  logic          dir_up;
  logic          dir_nxt;
  logic          done_q;
  logic          done_qq;
  logic [7:0]    dist_q;
  logic [7:0]    run_min;
  logic [3:0]    run_angle;
  logic          rise_c;
  logic          sweep_end_c;
  logic [7:0]    sample_c;
  logic [3:0]    drive_step_c;

  assign rise_c      = done_q & ~done_qq;
  assign sample_c    = rise_c ? dist_q : 8'hFF;
  assign sweep_end_c = dir_up ? (step == LAST_STEP) : (step == 4'd0);

  // Next angle: walk in the current direction, or turn around at an endpoint
  always_comb begin
    step_nxt = step;
    dir_nxt  = dir_up;
    if (!sweep_end_c) begin
      step_nxt = dir_up ? step + 4'd1 : step - 4'd1;
    end else begin
      dir_nxt = ~dir_up;
      if (N_STEPS > 1) step_nxt = dir_up ? LAST_STEP - 4'd1 : 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      if (start && !stop) state_nxt = S_MOVE;
    end else if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_MOVE:  if (cnt == SETTLE_END) state_nxt = S_GAP;
        S_GAP:   state_nxt = S_MEAS;
        S_MEAS:  if (rise_c || cnt == TMO_END) state_nxt = S_STORE;
        S_STORE: state_nxt = S_GAP2;
        S_GAP2:  state_nxt = (sweep_end_c && !continuous) ? S_IDLE : S_MOVE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Step driven on the servo/sensor in the state being entered
  always_comb begin
    drive_step_c = step;
    if (state == S_IDLE) drive_step_c = 4'd0;
    else if (state == S_GAP2) drive_step_c = step_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      step       <= 4'd0;
      dir_up     <= 1'b1;
      done_q     <= 1'b0;
      done_qq    <= 1'b0;
      dist_q     <= 8'd0;
      run_min    <= 8'hFF;
      run_angle  <= 4'd0;
      enable_sm  <= 1'b0;
      enable_us  <= 1'b0;
      period     <= 8'd0;
      dutty      <= 4'd0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_angle  <= 4'd0;
      res_dist   <= 8'd0;
      res_tmo    <= 1'b0;
      sweep_done <= 1'b0;
      min_dist   <= 8'hFF;
      min_angle  <= 4'd0;
    end else begin
      state   <= state_nxt;
      done_q  <= us_done;
      done_qq <= done_q;
      dist_q  <= us_dist;

      if (state_nxt != state) cnt <= '0;
      else if (state == S_MOVE || state == S_MEAS) cnt <= cnt + CW'(1);

      enable_sm <= (state_nxt == S_MOVE);
      enable_us <= (state_nxt == S_MEAS);
      busy      <= (state_nxt != S_IDLE);
      res_valid <= (state_nxt == S_STORE);
      period    <= (state_nxt == S_MOVE) ? PERIOD_SM :
                   (state_nxt == S_MEAS) ? PERIOD_US : 8'd0;
      dutty     <= (state_nxt == S_MOVE || state_nxt == S_MEAS) ? DBASE + drive_step_c : 4'd0;

      if (state == S_IDLE && state_nxt == S_MOVE) begin
        step      <= 4'd0;
        dir_up    <= 1'b1;
        run_min   <= 8'hFF;
        run_angle <= 4'd0;
      end

      if (state == S_GAP2 && state_nxt == S_MOVE) begin
        step   <= step_nxt;
        dir_up <= dir_nxt;
      end

      // Strict compare keeps the earliest sample of the sweep on ties
      if (state == S_MEAS && state_nxt == S_STORE) begin
        res_angle <= step;
        res_dist  <= sample_c;
        res_tmo   <= ~rise_c;
        if (sample_c < run_min) begin
          run_min   <= sample_c;
          run_angle <= step;
        end
      end

      sweep_done <= 1'b0;
      if (state == S_STORE && state_nxt == S_GAP2 && sweep_end_c) begin
        sweep_done <= 1'b1;
        min_dist   <= run_min;
        min_angle  <= run_angle;
        run_min    <= 8'hFF;
        run_angle  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_radar_sweep_sequencer.sv
// Directed bench for radar_sweep_sequencer with N_STEPS=3, SETTLE_CYCLES=4, US_TIMEOUT=10.
module tb_radar_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic       us_done = 1'b0;
  logic [7:0] us_dist = 8'd0;
  logic       enable_sm, enable_us, busy, res_valid, res_tmo, sweep_done;
  logic [7:0] period, res_dist, min_dist;
  logic [3:0] dutty, res_angle, min_angle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radar_sweep_sequencer #(
    .N_STEPS(3), .DUTY_BASE(2), .PERIOD_SM(8'd20), .PERIOD_US(8'd60),
    .SETTLE_CYCLES(4), .US_TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .us_done(us_done), .us_dist(us_dist),
    .enable_sm(enable_sm), .enable_us(enable_us), .period(period), .dutty(dutty),
    .busy(busy), .res_valid(res_valid), .res_angle(res_angle), .res_dist(res_dist),
    .res_tmo(res_tmo), .sweep_done(sweep_done), .min_dist(min_dist), .min_angle(min_angle)
  );

  // Observation log filled on every falling edge
  logic [12:0] res_q[$];
  logic [3:0]  duty_q[$];
  int          us_len_q[$];
  int          sd_q[$];
  logic [11:0] sd_min_q[$];
  int cyc = 0, sm_fall = -100, sm_len = 0, us_len = 0;
  int excl_err = 0, gap_err = 0, settle_err = 0, per_err = 0;
  logic prev_sm = 1'b0, prev_us = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (enable_sm && enable_us) excl_err = excl_err + 1;
    if (enable_sm && period !== 8'd20) per_err = per_err + 1;
    if (enable_us && period !== 8'd60) per_err = per_err + 1;
    if (enable_sm && !prev_sm) duty_q.push_back(dutty);
    if (enable_sm) sm_len = sm_len + 1;
    if (!enable_sm && prev_sm) begin
      if (sm_len != 4) settle_err = settle_err + 1;
      sm_len  = 0;
      sm_fall = cyc;
    end
    if (enable_us && !prev_us && (cyc - sm_fall) != 1) gap_err = gap_err + 1;
    if (enable_us) us_len = us_len + 1;
    if (!enable_us && prev_us) begin
      us_len_q.push_back(us_len);
      us_len = 0;
    end
    if (res_valid) res_q.push_back({res_angle, res_dist, res_tmo});
    if (sweep_done) begin
      sd_q.push_back(res_q.size());
      sd_min_q.push_back({min_angle, min_dist});
    end
    prev_sm = enable_sm;
    prev_us = enable_us;
  end

  function automatic logic [12:0] pk(input int a, input int d, input bit t);
    return {4'(a), 8'(d), t};
  endfunction

  task automatic clear_mon();
    res_q.delete(); duty_q.delete(); us_len_q.delete(); sd_q.delete(); sd_min_q.delete();
    excl_err = 0; gap_err = 0; settle_err = 0; per_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Radar stand-in: answer one measurement window (d < 0 means never answer)
  task automatic serve(input int d, input int dly);
    int n;
    n = 0;
    while (enable_us !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (enable_us !== 1'b1) begin
      errors++;
      $display("FAIL serve_enter enable_us=%b required 1", enable_us);
      return;
    end
    if (d >= 0) begin
      repeat (dly) @(negedge clk);
      us_dist = 8'(d);
      us_done = 1'b1;
    end
    n = 0;
    while (enable_us === 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (enable_us !== 1'b0) begin
      errors++;
      $display("FAIL serve_exit enable_us=%b required 0", enable_us);
    end
    us_done = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({enable_sm, enable_us, busy, res_valid, sweep_done, res_tmo} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 000000",
               {enable_sm, enable_us, busy, res_valid, sweep_done, res_tmo});
    end
    checks++;
    if ({period, dutty, res_dist, res_angle} !== 24'd0) begin
      errors++;
      $display("FAIL reset_data period=%0d dutty=%0d res_dist=%0d res_angle=%0d required 0",
               period, dutty, res_dist, res_angle);
    end
    checks++;
    if (min_dist !== 8'hFF || min_angle !== 4'd0) begin
      errors++;
      $display("FAIL reset_min got %h/%0d required ff/0", min_dist, min_angle);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_sweep();
    logic [12:0] er[3];
    logic [3:0]  ed[3];
    er = '{pk(0, 40, 0), pk(1, 25, 0), pk(2, 60, 0)};
    ed = '{4'd2, 4'd3, 4'd4};
    clear_mon();
    continuous = 1'b0;
    pulse_start();
    serve(40, 2);
    serve(25, 2);
    serve(60, 2);
    wait_idle(50);
    checks++;
    if (res_q.size() != 3) begin
      errors++; $display("FAIL single_count got %0d required 3", res_q.size());
    end
    for (int i = 0; i < 3 && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== er[i]) begin
        errors++; $display("FAIL single_res%0d got %h required %h", i, res_q[i], er[i]);
      end
    end
    for (int i = 0; i < 3 && i < duty_q.size(); i++) begin
      checks++;
      if (duty_q[i] !== ed[i]) begin
        errors++; $display("FAIL single_duty%0d got %0d required %0d", i, duty_q[i], ed[i]);
      end
    end
    checks++;
    if (sd_q.size() != 1 || sd_q[0] != 3) begin
      errors++; $display("FAIL single_sweep_done count=%0d required 1 after sample 3", sd_q.size());
    end
    checks++;
    if (min_dist !== 8'd25 || min_angle !== 4'd1) begin
      errors++; $display("FAIL single_min got %0d/%0d required 25/1", min_dist, min_angle);
    end
    checks++;
    if (excl_err != 0 || gap_err != 0 || settle_err != 0 || per_err != 0) begin
      errors++;
      $display("FAIL single_timing excl=%0d gap=%0d settle=%0d period=%0d required 0",
               excl_err, gap_err, settle_err, per_err);
    end
  endtask

  task automatic test_timeout();
    logic [12:0] er[3];
    er = '{pk(0, 40, 0), pk(1, 255, 1), pk(2, 90, 0)};
    clear_mon();
    pulse_start();
    serve(40, 1);
    serve(-1, 0);
    serve(90, 3);
    wait_idle(50);
    checks++;
    if (res_q.size() != 3) begin
      errors++; $display("FAIL tmo_count got %0d required 3", res_q.size());
    end
    for (int i = 0; i < 3 && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== er[i]) begin
        errors++; $display("FAIL tmo_res%0d got %h required %h", i, res_q[i], er[i]);
      end
    end
    checks++;
    if (us_len_q.size() < 2 || us_len_q[1] != 10) begin
      errors++; $display("FAIL tmo_window got %0d cycles required 10",
                         (us_len_q.size() < 2) ? -1 : us_len_q[1]);
    end
    checks++;
    if (min_dist !== 8'd40 || min_angle !== 4'd0) begin
      errors++; $display("FAIL tmo_min got %0d/%0d required 40/0", min_dist, min_angle);
    end
    checks++;
    if (excl_err != 0 || gap_err != 0 || settle_err != 0 || per_err != 0) begin
      errors++;
      $display("FAIL tmo_timing excl=%0d gap=%0d settle=%0d period=%0d required 0",
               excl_err, gap_err, settle_err, per_err);
    end
  endtask

  task automatic test_ping_pong();
    int          dv[6];
    int          av[6];
    logic [3:0]  ed[6];
    dv = '{30, 20, 10, 5, 50, 70};
    av = '{0, 1, 2, 1, 0, 1};
    ed = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd3};
    clear_mon();
    continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) serve(dv[i], 2);
    repeat (2) @(negedge clk);
    checks++;
    if (res_q.size() != 6) begin
      errors++; $display("FAIL pp_count got %0d required 6", res_q.size());
    end
    for (int i = 0; i < 6 && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== pk(av[i], dv[i], 0)) begin
        errors++; $display("FAIL pp_res%0d got %h required %h", i, res_q[i], pk(av[i], dv[i], 0));
      end
    end
    for (int i = 0; i < 6 && i < duty_q.size(); i++) begin
      checks++;
      if (duty_q[i] !== ed[i]) begin
        errors++; $display("FAIL pp_duty%0d got %0d required %0d", i, duty_q[i], ed[i]);
      end
    end
    checks++;
    if (sd_q.size() != 2 || sd_q[0] != 3 || sd_q[1] != 5) begin
      errors++; $display("FAIL pp_sweep_done count=%0d required 2 after samples 3 and 5", sd_q.size());
    end
    checks++;
    if (sd_min_q.size() != 2 || sd_min_q[0] !== {4'd2, 8'd10} || sd_min_q[1] !== {4'd1, 8'd5}) begin
      errors++; $display("FAIL pp_sweep_min count=%0d required 2a/105", sd_min_q.size());
    end
    checks++;
    if (excl_err != 0 || gap_err != 0 || settle_err != 0 || per_err != 0) begin
      errors++;
      $display("FAIL pp_timing excl=%0d gap=%0d settle=%0d period=%0d required 0",
               excl_err, gap_err, settle_err, per_err);
    end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    continuous = 1'b0;
    checks++;
    if (busy !== 1'b0 || enable_sm !== 1'b0 || enable_us !== 1'b0) begin
      errors++; $display("FAIL pp_stop busy=%b sm=%b us=%b required 0", busy, enable_sm, enable_us);
    end
    checks++;
    if (min_dist !== 8'd5 || min_angle !== 4'd1) begin
      errors++; $display("FAIL pp_min got %0d/%0d required 5/1", min_dist, min_angle);
    end
  endtask

  task automatic test_stale_done();
    int n;
    clear_mon();
    us_dist = 8'd99;
    us_done = 1'b1;
    pulse_start();
    n = 0;
    while (enable_us !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    us_done = 1'b0;
    repeat (2) @(negedge clk);
    us_dist = 8'd77;
    us_done = 1'b1;
    n = 0;
    while (enable_us === 1'b1 && n < 40) begin @(negedge clk); n++; end
    us_done = 1'b0;
    @(negedge clk);
    checks++;
    if (res_q.size() != 1 || res_q[0] !== pk(0, 77, 0)) begin
      errors++; $display("FAIL stale_res count=%0d got %h required %h", res_q.size(),
                         (res_q.size() > 0) ? res_q[0] : 13'h0, pk(0, 77, 0));
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(5);
    checks++;
    if (min_dist !== 8'd5 || sd_q.size() != 0) begin
      errors++; $display("FAIL stale_min got %0d sweeps=%0d required 5/0", min_dist, sd_q.size());
    end
  endtask

  task automatic test_abort_reset();
    int n;
    clear_mon();
    pulse_start();
    n = 0;
    while (enable_us !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); stop = 1'b1; us_dist = 8'd3; us_done = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || enable_us !== 1'b0 || enable_sm !== 1'b0 || period !== 8'd0) begin
      errors++; $display("FAIL abort_state busy=%b us=%b sm=%b period=%0d required 0",
                         busy, enable_us, enable_sm, period);
    end
    repeat (5) @(negedge clk);
    us_done = 1'b0;
    checks++;
    if (res_q.size() != 0 || sd_q.size() != 0) begin
      errors++; $display("FAIL abort_pulses res=%0d sweep=%0d required 0", res_q.size(), sd_q.size());
    end
    checks++;
    if (min_dist !== 8'd5 || min_angle !== 4'd1) begin
      errors++; $display("FAIL abort_min got %0d/%0d required 5/1", min_dist, min_angle);
    end
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stop_wins busy=%b required 0", busy);
    end
    pulse_start();
    n = 0;
    while (enable_sm !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (enable_sm !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || period !== 8'd0 || dutty !== 4'd0) begin
      errors++; $display("FAIL rst_state sm=%b busy=%b rv=%b period=%0d dutty=%0d required 0",
                         enable_sm, busy, res_valid, period, dutty);
    end
    checks++;
    if (min_dist !== 8'hFF || min_angle !== 4'd0) begin
      errors++; $display("FAIL rst_min got %h/%0d required ff/0", min_dist, min_angle);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_q.size() != 0) begin
      errors++; $display("FAIL rst_quiet busy=%b res=%0d required 0/0", busy, res_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_timeout();
    test_ping_pong();
    test_stale_done();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
